data_stream_gen: RTL and testbench

//  Parametrised successor to the single-bit data_stream source: emits DATA_W-bit words on a valid/ready stream.

---
 rtl/data_stream_gen_if.sv | 24 ++
 rtl/data_stream_gen.sv | 131 +++++++++++++
 tb/tb_data_stream_gen.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_stream_gen_if.sv
// Valid/ready word stream between data_stream_gen and its sink.
// master drives data/valid/last, slave returns ready.
interface data_stream_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/data_stream_gen.sv
// Pattern word generator (count/PRBS16/alternate/walking one) on a valid/ready stream.
// Optional DSG_ERR_INJECT_EN: err_inject flips bit 0 of the next transferred word.
module data_stream_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [15:0]      seed,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             err_inject,
  output logic             busy,
  output logic             done,
  data_stream_gen_if.master m
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [1:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      gen;
  logic [15:0]      gen_next;
  logic [15:0]      gen_init;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] wn;
  logic             fb;
  logic             err_arm;
  logic             run;
  logic             xfer;
  logic             last_word;
  logic             finish;
  logic             go;

  assign run       = (state == RUN);
  assign xfer      = run & m.ready;
  assign last_word = (cfg_len != '0) &&
                     (cnt == cfg_len - 1'b1);
  assign finish    = run & (abort | (xfer & last_word));
  assign go        = !run & start & !abort;

  assign busy    = run;
  assign m.valid = run;
  assign m.last  = run & last_word;
  assign m.data  = run ?
    (gen[DATA_W-1:0] ^ DATA_W'(err_arm)) : '0;

  // Next generator state for the active pattern.
  always_comb begin
    w        = gen[DATA_W-1:0];
    fb       = gen[0] ^ gen[2] ^ gen[3] ^ gen[5];
    wn       = w;
    gen_next = gen;
    unique case (cfg_mode)
      2'd0: begin
        wn       = w + DATA_W'(1);
        gen_next = 16'(wn);
      end
      2'd1: gen_next = {fb, gen[15:1]};
      2'd2: begin
        wn       = ~w;
        gen_next = 16'(wn);
      end
      default: begin
        wn       = (w << 1) | (w >> (DATA_W - 1));
        gen_next = 16'(wn);
      end
    endcase
  end

  // First word of a burst; zero seed would lock the LFSR.
  always_comb begin
    gen_init = 16'(seed[DATA_W-1:0]);
    unique case (mode)
      2'd1:    gen_init = (seed == 16'd0) ? 16'hACE1 : seed;
      2'd3:    gen_init = 16'd1;
      default: gen_init = 16'(seed[DATA_W-1:0]);
    endcase
  end

  // Burst control, config capture and pattern advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg_mode <= 2'd0;
      cfg_len  <= '0;
      cnt      <= '0;
      gen      <= 16'd0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (go) begin
        state    <= RUN;
        cfg_mode <= mode;
        cfg_len  <= burst_len;
        cnt      <= '0;
        gen      <= gen_init;
      end else if (finish) begin
        state <= IDLE;
      end else if (xfer) begin
        gen <= gen_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DSG_ERR_INJECT_EN
  // Armed flag corrupts exactly one transferred word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_arm <= 1'b0;
    end else if (finish) begin
      err_arm <= 1'b0;
    end else if (err_inject) begin
      err_arm <= 1'b1;
    end else if (xfer) begin
      err_arm <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_inject;
  assign err_arm    = 1'b0;
`endif

endmodule

// File: tb/tb_data_stream_gen.sv
// Directed bench for data_stream_gen: burst table plus stall/abort/reset sequences.
// Runs an 8-bit and a 16-bit instance side by side on shared inputs.
module tb_data_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [15:0] burst_len;
  logic        err_inject;
  logic        ready;
  logic        busy8, done8, busy16, done16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_stream_gen_if #(.DATA_W(8))  if8 ();
  data_stream_gen_if #(.DATA_W(16)) if16 ();

  assign if8.ready  = ready;
  assign if16.ready = ready;

  data_stream_gen #(.DATA_W(8), .LEN_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .mode(mode), .seed(seed),
    .burst_len(burst_len), .err_inject(err_inject),
    .busy(busy8), .done(done8), .m(if8.master)
  );

  data_stream_gen #(.DATA_W(16), .LEN_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .mode(mode), .seed(seed),
    .burst_len(burst_len), .err_inject(err_inject),
    .busy(busy16), .done(done16), .m(if16.master)
  );

  typedef struct {
    logic [1:0]       mode;
    logic [15:0]      seed;
    logic [15:0]      len;
    bit               chk16;
    logic [8:0][7:0]  w8;
    logic [8:0][15:0] w16;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] md,
                             input logic [15:0] sd,
                             input logic [15:0] ln);
    mode      = md;
    seed      = sd;
    burst_len = ln;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    ready = 1'b1;
    pulse_start(v.mode, v.seed, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d valid[%0d]", k, i),
          16'(if8.valid), 16'd1);
      chk($sformatf("v%0d data[%0d]", k, i),
          16'(if8.data), 16'(v.w8[i]));
      chk($sformatf("v%0d last[%0d]", k, i),
          16'(if8.last),
          16'(i == int'(v.len) - 1));
      if (v.chk16)
        chk($sformatf("v%0d data16[%0d]", k, i),
            if16.data, v.w16[i]);
      step();
    end
    chk($sformatf("v%0d done", k), 16'(done8), 16'd1);
    chk($sformatf("v%0d end valid", k),
        16'(if8.valid), 16'd0);
    chk($sformatf("v%0d end busy", k), 16'(busy8), 16'd0);
    step();
    chk($sformatf("v%0d done clr", k), 16'(done8), 16'd0);
  endtask

  logic [7:0] exp_w [4];
  logic [7:0] alt_w [5];

  initial begin
    vecs[0] = '{2'd0, 16'h00FE, 16'd4, 1'b0,
      {8'h0,8'h0,8'h0,8'h0,8'h0,8'h01,8'h00,8'hFF,8'hFE},
      '0};
    vecs[1] = '{2'd1, 16'hACE1, 16'd3, 1'b1,
      {8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h38,8'h70,8'hE1},
      {16'h0,16'h0,16'h0,16'h0,16'h0,16'h0,
       16'hAB38,16'h5670,16'hACE1}};
    vecs[2] = '{2'd1, 16'h0000, 16'd2, 1'b1,
      {8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h70,8'hE1},
      {16'h0,16'h0,16'h0,16'h0,16'h0,16'h0,
       16'h0,16'h5670,16'hACE1}};
    vecs[3] = '{2'd3, 16'h1234, 16'd9, 1'b1,
      {8'h01,8'h80,8'h40,8'h20,8'h10,8'h08,8'h04,8'h02,8'h01},
      {16'h0100,16'h0080,16'h0040,16'h0020,16'h0010,
       16'h0008,16'h0004,16'h0002,16'h0001}};
    vecs[4] = '{2'd2, 16'h005A, 16'd3, 1'b0,
      {8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h5A,8'hA5,8'h5A},
      '0};
    vecs[5] = '{2'd0, 16'h00FF, 16'd1, 1'b0,
      {8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'hFF},
      '0};

    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    mode = 2'd0; seed = 16'h0; burst_len = 16'd4;
    err_inject = 1'b0; ready = 1'b1;

    // reset with start held
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst valid", 16'(if8.valid), 16'd0);
      chk("rst data", 16'(if8.data), 16'd0);
      chk("rst last", 16'(if8.last), 16'd0);
      chk("rst busy", 16'(busy8), 16'd0);
      chk("rst done", 16'(done8), 16'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post rst busy", 16'(busy8), 16'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // stall on walking one, start while running ignored
    ready = 1'b0;
    pulse_start(2'd3, 16'h0, 16'd3);
    chk("stall d0", 16'(if8.data), 16'h01);
    mode = 2'd0; seed = 16'h0077; start = 1'b1;
    step();
    start = 1'b0;
    chk("stall d1", 16'(if8.data), 16'h01);
    chk("stall v1", 16'(if8.valid), 16'd1);
    chk("stall l1", 16'(if8.last), 16'd0);
    ready = 1'b1;
    step();
    chk("stall d2", 16'(if8.data), 16'h02);
    ready = 1'b0;
    step();
    chk("stall d3", 16'(if8.data), 16'h02);
    ready = 1'b1;
    step();
    chk("stall d4", 16'(if8.data), 16'h04);
    chk("stall last", 16'(if8.last), 16'd1);
    ready = 1'b0;
    step();
    chk("stall last hold", 16'(if8.last), 16'd1);
    chk("stall no done", 16'(done8), 16'd0);
    ready = 1'b1;
    step();
    chk("stall done", 16'(done8), 16'd1);
    step();

    // continuous alternate, abort on 5th word
    alt_w = '{8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    pulse_start(2'd2, 16'h005A, 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("alt data[%0d]", i),
          16'(if8.data), 16'(alt_w[i]));
      chk($sformatf("alt last[%0d]", i),
          16'(if8.last), 16'd0);
      if (i == 4) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    chk("abort done", 16'(done8), 16'd1);
    chk("abort busy", 16'(busy8), 16'd0);
    chk("abort valid", 16'(if8.valid), 16'd0);
    step();
    chk("abort done clr", 16'(done8), 16'd0);

    // abort together with start in idle
    abort = 1'b1;
    pulse_start(2'd0, 16'h0, 16'd2);
    abort = 1'b0;
    chk("abort+start busy", 16'(busy8), 16'd0);
    chk("abort+start done", 16'(done8), 16'd0);

    // reset mid-burst
    pulse_start(2'd0, 16'h0010, 16'd5);
    step();
    chk("mid data", 16'(if8.data), 16'h11);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid rst valid", 16'(if8.valid), 16'd0);
    chk("mid rst done", 16'(done8), 16'd0);
    step();
    chk("mid rst done2", 16'(done8), 16'd0);

    // error injection before third word
`ifdef DSG_ERR_INJECT_EN
    exp_w = '{8'h00, 8'h01, 8'h03, 8'h03};
`else
    exp_w = '{8'h00, 8'h01, 8'h02, 8'h03};
`endif
    pulse_start(2'd0, 16'h0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("err data[%0d]", i),
          16'(if8.data), 16'(exp_w[i]));
      err_inject = (i == 1);
      step();
      err_inject = 1'b0;
    end
    chk("err done", 16'(done8), 16'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
